// File: rtl/instruction_cache.sv
// ============================================================================
// Module   : instruction_cache
// Purpose  : Direct-mapped read-only instruction cache with whole-line refill.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instruction_cache #(
    parameter int INDEX_BITS = 6,
    parameter int BLOCK_BITS = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        ins_asked,
    input  logic [31:0] ins_addr,
    output logic        ic_rdy,
    output logic [31:0] ins,
    output logic        mc_ask,
    output logic [31:0] mc_addr,
    input  logic        mc_rdy,
    input  logic [31:0] mc_data
);

    localparam int c_LINES  = 2 ** INDEX_BITS;
    localparam int c_WORDS  = 2 ** BLOCK_BITS;
    localparam int c_IDX_LO = BLOCK_BITS + 2;
    localparam int c_TAG_LO = INDEX_BITS + BLOCK_BITS + 2;
    localparam int c_TAG_W  = 32 - c_TAG_LO;
    localparam logic [BLOCK_BITS-1:0] c_LAST = '1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REFILL  = 2'd1,
        S_RESPOND = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;

    logic [c_LINES-1:0]      r_valid;
    logic [c_TAG_W-1:0]      r_tag  [c_LINES];
    logic [31:0]             r_data [c_LINES][c_WORDS];
    logic [31:0]             r_req_addr;
    logic [BLOCK_BITS-1:0]   r_cnt;

    logic [BLOCK_BITS-1:0]   w_in_off;
    logic [INDEX_BITS-1:0]   w_in_idx;
    logic [c_TAG_W-1:0]      w_in_tag;
    logic [BLOCK_BITS-1:0]   w_rq_off;
    logic [INDEX_BITS-1:0]   w_rq_idx;
    logic [c_TAG_W-1:0]      w_rq_tag;
    logic [BLOCK_BITS-1:0]   w_cnt_inc;
    logic                    w_hit;
    logic                    w_fill_we;
    logic                    w_unused_bits;

    assign w_in_off  = ins_addr[c_IDX_LO-1:2];
    assign w_in_idx  = ins_addr[c_TAG_LO-1:c_IDX_LO];
    assign w_in_tag  = ins_addr[31:c_TAG_LO];
    assign w_rq_off  = r_req_addr[c_IDX_LO-1:2];
    assign w_rq_idx  = r_req_addr[c_TAG_LO-1:c_IDX_LO];
    assign w_rq_tag  = r_req_addr[31:c_TAG_LO];
    assign w_cnt_inc = r_cnt + BLOCK_BITS'(1);
    assign w_hit     = r_valid[w_in_idx] && (r_tag[w_in_idx] == w_in_tag);
    assign w_fill_we = !rst && rdy && (r_state == S_REFILL) && mc_rdy;
    assign w_unused_bits = ^{ins_addr[1:0], r_req_addr[1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else if (rdy) begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (ins_asked && !w_hit) begin
                    w_state_nxt = S_REFILL;
                end
            end
            S_REFILL: begin
                if (mc_rdy && (r_cnt == c_LAST)) begin
                    w_state_nxt = S_RESPOND;
                end
            end
            S_RESPOND: w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    // Line storage carries no reset; only the valid bits gate its use.
    always_ff @(posedge clk) begin
        if (w_fill_we) begin
            r_data[w_rq_idx][r_cnt] <= mc_data;
            if (r_cnt == c_LAST) begin
                r_tag[w_rq_idx] <= w_rq_tag;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid    <= '0;
            r_req_addr <= '0;
            r_cnt      <= '0;
            ic_rdy     <= 1'b0;
            ins        <= '0;
            mc_ask     <= 1'b0;
            mc_addr    <= '0;
        end else if (rdy) begin
            case (r_state)
                S_IDLE: begin
                    ic_rdy <= 1'b0;
                    if (ins_asked) begin
                        r_req_addr <= ins_addr;
                        if (w_hit) begin
                            ic_rdy <= 1'b1;
                            ins    <= r_data[w_in_idx][w_in_off];
                        end else begin
                            // Invalidate up front so a half-filled line never hits.
                            r_valid[w_in_idx] <= 1'b0;
                            r_cnt             <= '0;
                            mc_ask            <= 1'b1;
                            mc_addr           <= {ins_addr[31:c_IDX_LO], {BLOCK_BITS{1'b0}}, 2'b00};
                        end
                    end
                end
                S_REFILL: begin
                    if (mc_rdy) begin
                        if (r_cnt != c_LAST) begin
                            r_cnt   <= w_cnt_inc;
                            mc_addr <= {mc_addr[31:c_IDX_LO], w_cnt_inc, 2'b00};
                        end else begin
                            mc_ask            <= 1'b0;
                            r_valid[w_rq_idx] <= 1'b1;
                        end
                    end
                end
                S_RESPOND: begin
                    ic_rdy <= 1'b1;
                    ins    <= r_data[w_rq_idx][w_rq_off];
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire
